// File: rtl/phy_free_list_ctrl.sv
// phy_free_list_ctrl: circular free list of physical registers with speculative head, committed head and release tail
module phy_free_list_ctrl #(
  parameter int PHYSICAL_REG_NUM_WIDTH = 7,
  parameter int ARCH_REG_NUM = 32,
  parameter int MAX_NUM_OF_COMMITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic alloc_req,
  output logic alloc_valid,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_reg,
  input  logic [MAX_NUM_OF_COMMITS-1:0] commit_valid,
  input  logic [MAX_NUM_OF_COMMITS-1:0] commit_with_write,
  input  logic [MAX_NUM_OF_COMMITS-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  input  logic flush,
  output logic [PHYSICAL_REG_NUM_WIDTH:0] free_count,
  output logic overflow_err
);
  localparam int W = PHYSICAL_REG_NUM_WIDTH;
  localparam int C = MAX_NUM_OF_COMMITS;
  localparam int DEPTH = 1 << W;
  localparam logic [W:0] DEPTH_P = {1'b1, {W{1'b0}}};
  localparam logic [W:0] TAIL_INIT = DEPTH_P - (W+1)'(ARCH_REG_NUM);
  logic [W-1:0] mem [DEPTH];
  logic [W:0] head, cmt_head, tail, fit, n, k;
  logic [W:0] off [C];
  logic [C-1:0] wr_lane, wen;
  assign free_count = tail - head;
  assign alloc_valid = free_count != '0;
  assign alloc_reg = mem[head[W-1:0]];
  // lanes that fit are always the lowest set lanes, so a lane's offset is the count of set lanes below it
  always_comb begin
    wr_lane = commit_valid & commit_with_write;
    fit = DEPTH_P - free_count;
    n = '0;
    k = '0;
    wen = '0;
    for (int i = 0; i < C; i++) begin
      off[i] = n;
      wen[i] = wr_lane[i] && (n < fit);
      n = n + (W+1)'(wr_lane[i]);
      k = k + (W+1)'(wen[i]);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= '0;
      cmt_head <= '0;
      tail <= TAIL_INIT;
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= i < DEPTH - ARCH_REG_NUM ? W'(ARCH_REG_NUM + i) : '0;
    end else begin
      head <= flush ? cmt_head + n : head + (W+1)'(alloc_req && alloc_valid);
      cmt_head <= cmt_head + n;
      tail <= tail + k;
      if (n > fit) overflow_err <= 1'b1;
      for (int i = 0; i < C; i++) if (wen[i]) mem[W'(tail + off[i])] <= commited_wr_register[i];
    end
endmodule

// File: tb/tb_phy_free_list_ctrl.sv
// tb_phy_free_list_ctrl: queue-based reference model feeding a scoreboard, with directed boundary checks
module tb_phy_free_list_ctrl;
  localparam int W = 7, C = 4, D = 128, A = 32;
  logic clk = 0, reset = 0, alloc_req = 0, flush = 0;
  logic alloc_valid, overflow_err;
  logic [W-1:0] alloc_reg;
  logic [C-1:0] commit_valid = '0, commit_with_write = '0;
  logic [C-1:0][W-1:0] commited_wr_register = '0;
  logic [W:0] free_count;
  phy_free_list_ctrl #(.PHYSICAL_REG_NUM_WIDTH(W), .ARCH_REG_NUM(A), .MAX_NUM_OF_COMMITS(C)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .commit_valid(commit_valid), .commit_with_write(commit_with_write),
    .commited_wr_register(commited_wr_register), .flush(flush), .free_count(free_count),
    .overflow_err(overflow_err));
  always #5 clk = ~clk;
  typedef struct {bit av; int r; int fc; bit ov;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int free_q[$], infl[$];
  bit m_ovf;
  int total = 0, bad = 0;
  function automatic void chk(string nm, longint act, longint ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, ex, $time);
    end
  endfunction
  function automatic void model_reset();
    free_q.delete();
    infl.delete();
    for (int i = 0; i < D - A; i++) free_q.push_back(A + i);
    m_ovf = 0;
  endfunction
  function automatic void push_exp();
    exp_t x;
    x.av = free_q.size() != 0;
    x.r = x.av ? free_q[0] : 0;
    x.fc = free_q.size();
    x.ov = m_ovf;
    exp_q.push_back(x);
  endfunction
  // free_q: registers available to rename, in hand-out order; infl: handed out but not yet committed
  task automatic step(input bit req, input bit [C-1:0] cv, input bit [C-1:0] cw,
                      input logic [C-1:0][W-1:0] regs, input bit fl);
    int acc[$];
    int n = 0;
    int fit;
    @(posedge clk);
    #1;
    alloc_req = req;
    commit_valid = cv;
    commit_with_write = cw;
    commited_wr_register = regs;
    flush = fl;
    push_exp();
    fit = D - free_q.size();
    for (int c = 0; c < C; c++)
      if (cv[c] && cw[c]) begin
        n++;
        if (acc.size() < fit) acc.push_back(int'(regs[c]));
      end
    if (n > fit) m_ovf = 1;
    repeat (n) if (infl.size() != 0) void'(infl.pop_front());
    if (fl) while (infl.size() != 0) free_q.push_front(infl.pop_back());
    else if (req && free_q.size() != 0) infl.push_back(free_q.pop_front());
    foreach (acc[i]) free_q.push_back(acc[i]);
  endtask
  task automatic idle();
    step(0, '0, '0, '0, 0);
  endtask
  task automatic hold_reset(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #3;
      reset = 0;
      alloc_req = 0;
      commit_valid = '0;
      commit_with_write = '0;
      flush = 0;
      model_reset();
      push_exp();
    end
    @(posedge clk);
    #1;
    reset = 1;
  endtask
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("alloc_valid", alloc_valid, e.av);
      if (e.av) chk("alloc_reg", alloc_reg, e.r);
      chk("free_count", free_count, e.fc);
      chk("overflow_err", overflow_err, e.ov);
    end
  logic [C-1:0][W-1:0] r;
  bit [C-1:0] cv, cw, mask;
  int lim, k;
  initial begin
    model_reset();
    hold_reset(2);
    chk("reset_free_count", free_count, 96);
    chk("reset_alloc_valid", alloc_valid, 1);
    chk("reset_alloc_reg", alloc_reg, 32);
    chk("reset_overflow", overflow_err, 0);
    repeat (3) step(1, '0, '0, '0, 0);
    idle();
    chk("t2_alloc_reg", alloc_reg, 35);
    chk("t2_free_count", free_count, 93);
    r = '0;
    r[0] = 5;
    r[1] = 99;
    r[2] = 9;
    step(1, 4'b0111, 4'b0101, r, 0);
    idle();
    chk("t3_free_count", free_count, 94);
    hold_reset(1);
    repeat (4) step(1, '0, '0, '0, 0);
    r = '0;
    r[0] = 7;
    step(1, 4'b0001, 4'b0001, r, 1);
    idle();
    chk("t4_alloc_reg", alloc_reg, 33);
    chk("t4_free_count", free_count, 96);
    while (free_q.size() != 0) step(1, '0, '0, '0, 0);
    step(1, '0, '0, '0, 0);
    idle();
    chk("t5_empty_valid", alloc_valid, 0);
    chk("t5_empty_count", free_count, 0);
    r = '0;
    r[0] = 40;
    step(1, 4'b0001, 4'b0001, r, 0);
    chk("t5_no_bypass", alloc_valid, 0);
    idle();
    chk("t5_refill_valid", alloc_valid, 1);
    chk("t5_refill_reg", alloc_reg, 40);
    chk("t5_refill_count", free_count, 1);
    for (int t = 0; t < 600; t++) begin
      cv = 4'($urandom());
      cw = 4'($urandom());
      lim = infl.size() < C ? infl.size() : C;
      for (int c = C - 1; c >= 0; c--) if ($countones(cv & cw) > lim) cw[c] = 0;
      for (int c = 0; c < C; c++) r[c] = 7'($urandom());
      step($urandom_range(0, 9) < 8, cv, cw, r, $urandom_range(0, 31) == 0);
    end
    step(0, '0, '0, '0, 1);
    while (free_q.size() < 126) begin
      k = 126 - free_q.size() < C ? 126 - free_q.size() : C;
      mask = 4'((1 << k) - 1);
      for (int c = 0; c < C; c++) r[c] = 7'($urandom());
      step(0, mask, mask, r, 0);
    end
    step(0, 4'hF, 4'hF, r, 0);
    idle();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", free_count, 128);
    repeat (3) step(1, '0, '0, '0, 0);
    idle();
    chk("ovf_sticky", overflow_err, 1);
    chk("ovf_drain_count", free_count, 125);
    step(1, '0, '0, '0, 0);
    hold_reset(2);
    chk("rst2_free_count", free_count, 96);
    chk("rst2_alloc_reg", alloc_reg, 32);
    chk("rst2_overflow", overflow_err, 0);
    repeat (2) step(1, '0, '0, '0, 0);
    idle();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
